memory_cycle: RTL and testbench
===============================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-low reset; it is sampled on the rising edge of clk.
REQ-003 SHALL have ports: RegWriteM  input  1  register-file write enable from the MEM stage.
REQ-004 SHALL have ports: MemWriteM  input  1  data-memory store enable.
REQ-005 SHALL have ports: ResultSrcM  input  2  writeback result select; it is passed through unchanged.
REQ-006 SHALL have ports: RD_M  input  5  destination register index.
REQ-007 SHALL have ports: PCPlus4M  input  32  PC+4 of the instruction.
REQ-008 SHALL have ports: WriteDataM  input  32  store data.
REQ-009 SHALL have ports: ALU_ResultM  input  32  effective byte address, or the ALU result.
REQ-010 SHALL have ports: RegWriteW, ResultSrcW[1:0], RD_W[4:0], PCPlus4W[31:0], ALU_ResultW[31:0]  outputs  registered copies of the corresponding M-stage inputs.
REQ-011 SHALL have ports: ReadDataW  output  32  registered data-memory read data.
REQ-012 SHALL use a single clock domain, clk; there are no handshakes and no stall or flush inputs.

Function
REQ-013 SHALL contain a data memory of 1024 x 32-bit words.
REQ-014 Word index SHALL be ALU_ResultM[11:2].
REQ-015 Address bits [1:0] SHALL be ignored, so misaligned addresses resolve to the containing word.
REQ-016 Address bits [31:12] SHALL be ignored, so addresses wrap modulo 4 KiB.
REQ-017 Memory read SHALL be combinational (asynchronous) from the word selected by ALU_ResultM.
REQ-018 A store SHALL write the whole 32-bit WriteDataM into the selected word on the rising edge of clk when MemWriteM=1 and rst=1.
REQ-019 There SHALL be no byte or halfword writes and no sign extension.
REQ-020 Read-during-write to the same word in one cycle: ReadDataW SHALL capture the OLD contents, and the new value SHALL be visible from the next cycle.
REQ-021 Memory contents SHALL initialise to all zeros at time zero.
REQ-022 Memory contents SHALL NOT be cleared by reset.
REQ-023 On each rising edge with rst=1, the M->W register SHALL load RegWriteM, ResultSrcM, RD_M, PCPlus4M and ALU_ResultM into the W outputs, and the memory read value into ReadDataW.
REQ-024 Latency SHALL be exactly 1 cycle from the M inputs to all W outputs.
REQ-025 Outputs SHALL change only on clk rising edges; there are no combinational paths from inputs to outputs.
REQ-026 MemWriteM SHALL NOT be propagated to the W stage.
REQ-027 X or undefined control inputs while in reset SHALL NOT affect the outputs or the memory.

Reset
REQ-028 When rst=0 at a rising edge, all W outputs SHALL become 0: RegWriteW=0, ResultSrcW=2'b00, RD_W=5'd0, and PCPlus4W, ALU_ResultW and ReadDataW all 32'h0.
REQ-029 Reset SHALL have priority over all inputs.
REQ-030 Stores SHALL be suppressed at every edge where rst=0, including when MemWriteM=1.
REQ-031 Reset asserted mid-operation SHALL clear the pipeline register on the next edge, and the memory SHALL retain all previously stored data.
REQ-032 After rst returns to 1, the first rising edge SHALL capture live inputs normally.

Verification
REQ-033 Bench SHALL cover reset: hold rst=0 for 3 edges with arbitrary inputs -> all W outputs are 0, and a later load from any address returns 0.
REQ-034 Bench SHALL cover store then load: MemWriteM=1, ALU_ResultM=32'h80, WriteDataM=32'h0000D000, ResultSrcM=01, RegWriteM=0, RD_M=0, PCPlus4M=32'h00E00000 -> after the first edge, ReadDataW=0 (old data), ALU_ResultW=32'h80, ResultSrcW=01, PCPlus4W=32'h00E00000, RegWriteW=0. Keeping the same inputs, the next edge gives ReadDataW=32'h0000D000.
REQ-035 Bench SHALL cover aliasing: store 32'hCAFEBABE at address 32'h104, then load from 32'h1107 -> ReadDataW=32'hCAFEBABE, because index 65 is used for both addresses.
REQ-036 Bench SHALL cover the disabled store: MemWriteM=0 with WriteDataM=32'hFFFFFFFF at address 32'h80 -> the word keeps its prior value 32'h0000D000.
REQ-037 Bench SHALL cover reset blocking a store: rst=0 with MemWriteM=1, address 32'h200, data 32'h12345678 -> after release, a load from 32'h200 returns 0 and all W outputs were 0 during reset.
REQ-038 Bench SHALL cover pass-through: RegWriteM=1, RD_M=5'd31, ResultSrcM=2'b10, PCPlus4M=32'hFFFFFFFC -> one edge later the outputs match exactly, including the 5-bit RD boundary value.

Source files
------------

// File: rtl/memory_cycle.sv
// ---------------------------------------------------------------------------
// memory_cycle
//   MEM stage of a 5-stage RISC-V style pipeline: a 1024 x 32-bit data
//   memory plus the M->W pipeline register.
//
//   Ports
//     clk          in   rising-edge clock
//     rst          in   synchronous active-low reset (pipeline register only)
//     RegWriteM    in   register-file write enable from MEM stage
//     MemWriteM    in   word store enable (not forwarded to W)
//     ResultSrcM   in   [1:0]  writeback result select, passed through
//     RD_M         in   [4:0]  destination register index
//     PCPlus4M     in   [31:0] PC+4 of the instruction
//     WriteDataM   in   [31:0] store data
//     ALU_ResultM  in   [31:0] byte address / ALU result
//     RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW
//                  out  registered copies of the M-stage inputs
//     ReadDataW    out  [31:0] registered memory read data
// ---------------------------------------------------------------------------
module memory_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
);

    localparam int unsigned DEPTH = 1024;

    // Contents start at zero and are deliberately outside the reset domain,
    // so a mid-run reset never loses stored data.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic [9:0]  word_idx;
    logic [31:0] read_data;

    // Byte-offset bits and everything above 4 KiB are dropped: misaligned
    // addresses hit the containing word and addresses wrap modulo 4 KiB.
    assign word_idx  = ALU_ResultM[11:2];
    assign read_data = mem[word_idx];

    // Stores are gated by rst so a reset cycle can never corrupt memory,
    // even with MemWriteM or the address undefined.
    always_ff @(posedge clk) begin
        if (rst && MemWriteM) begin
            mem[word_idx] <= WriteDataM;
        end
    end

    // read_data is sampled before the store above lands, so a same-word
    // read-during-write captures the old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'h0;
            ALU_ResultW <= 32'h0;
            ReadDataW   <= 32'h0;
        end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= read_data;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;

    int checks   = 0;
    int failures = 0;

    memory_cycle dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .PCPlus4M   (PCPlus4M),
        .WriteDataM (WriteDataM),
        .ALU_ResultM(ALU_ResultM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RD_W       (RD_W),
        .PCPlus4W   (PCPlus4W),
        .ALU_ResultW(ALU_ResultW),
        .ReadDataW  (ReadDataW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic rw, input logic [1:0] rs,
                           input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] alu, input logic [31:0] rdata);
        check({tag, ".RegWriteW"},   {31'h0, RegWriteW},  {31'h0, rw});
        check({tag, ".ResultSrcW"},  {30'h0, ResultSrcW}, {30'h0, rs});
        check({tag, ".RD_W"},        {27'h0, RD_W},       {27'h0, rd});
        check({tag, ".PCPlus4W"},    PCPlus4W,            pc);
        check({tag, ".ALU_ResultW"}, ALU_ResultW,         alu);
        check({tag, ".ReadDataW"},   ReadDataW,           rdata);
    endtask

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] wd, input logic [31:0] alu);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = alu;
    endtask

    initial begin
        // Reset for three edges with a store pending and junk on the rest.
        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b11, 5'd17, 32'hDEADBEEF, 32'h12345678, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            check_w("reset", 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
            drive(1'b1, 1'b1, 2'(i), 5'(i + 3), 32'hA5A5_0000 + 32'(i), 32'h12345678, 32'h200);
        end

        // First edge after release captures live inputs; store at 0x200 was blocked.
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h4, 32'h0, 32'h200);
        step();
        check_w("post_reset_200", 1'b0, 2'b00, 5'd0, 32'h4, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h8, 32'h0, 32'hFFC);
        step();
        check("post_reset_ffc.ReadDataW", ReadDataW, 32'h0);

        // Store then load, same inputs for two edges.
        drive(1'b0, 1'b1, 2'b01, 5'd0, 32'h00E00000, 32'h0000D000, 32'h80);
        step();
        check_w("store_80_first", 1'b0, 2'b01, 5'd0, 32'h00E00000, 32'h80, 32'h0);
        step();
        check("store_80_second.ReadDataW", ReadDataW, 32'h0000D000);

        // Aliasing: 0x104 and 0x1107 both resolve to word 65.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h10, 32'hCAFEBABE, 32'h104);
        step();
        drive(1'b0, 1'b0, 2'b01, 5'd2, 32'h14, 32'h0, 32'h1107);
        step();
        check_w("alias_1107", 1'b0, 2'b01, 5'd2, 32'h14, 32'h1107, 32'hCAFEBABE);

        // Disabled store leaves the word at 0x80 untouched.
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h18, 32'hFFFFFFFF, 32'h80);
        step();
        check("nostore_80_a.ReadDataW", ReadDataW, 32'h0000D000);
        step();
        check("nostore_80_b.ReadDataW", ReadDataW, 32'h0000D000);

        // Pass-through of the boundary control values.
        drive(1'b1, 1'b0, 2'b10, 5'd31, 32'hFFFFFFFC, 32'h0, 32'h3FC);
        step();
        check_w("passthru", 1'b1, 2'b10, 5'd31, 32'hFFFFFFFC, 32'h3FC, 32'h0);

        // Mid-operation reset with a store attempt clears W but keeps memory.
        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 5'd9, 32'h20, 32'h77777777, 32'h80);
        step();
        check_w("mid_reset", 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b11, 5'd1, 32'h24, 32'h0, 32'h80);
        step();
        check_w("retain_80", 1'b1, 2'b11, 5'd1, 32'h24, 32'h80, 32'h0000D000);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h28, 32'h0, 32'h106);
        step();
        check("retain_106.ReadDataW", ReadDataW, 32'hCAFEBABE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
